// File: rtl/icp_host_if.sv
// Bus bundle between the ICP host driver, its X-byte source, the chip and the result sink.
interface icp_host_if;
    logic       job_go;
    logic [7:0] x_data;
    logic       x_valid;
    logic       x_ready;
    logic       start_in;
    logic [7:0] X_load;
    logic       valid_input;
    logic       read_n;
    logic [7:0] r_addr;
    logic       ry;
    logic [8:0] read_data;
    logic       finish;
    logic [8:0] res_data;
    logic [7:0] res_addr;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       err;

    modport master (
        input  job_go, x_data, x_valid, ry, read_data, finish, res_ready,
        output x_ready, start_in, X_load, valid_input, read_n, r_addr,
               res_data, res_addr, res_valid, busy, err
    );

    modport slave (
        output job_go, x_data, x_valid, ry, read_data, finish, res_ready,
        input  x_ready, start_in, X_load, valid_input, read_n, r_addr,
               res_data, res_addr, res_valid, busy, err
    );
endinterface

// File: rtl/icp_host_driver.sv
// Sequences one ICP chip job: start pulse, X-byte load, wait for finish,
// then reads back RES_CNT result words onto a valid/ready stream.
module icp_host_driver #(
    parameter int unsigned X_CNT   = 64,
    parameter int unsigned RES_CNT = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    icp_host_if.master bus
);
    localparam int unsigned CW = $clog2(X_CNT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, START, LOAD, WAIT_FIN, RD_REQ, RD_WAIT, RD_OUT, ERR
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [TW-1:0] tmo, tmo_d;

    logic       start_in_q, start_in_d;
    logic       valid_input_q, valid_input_d;
    logic [7:0] x_load_q, x_load_d;
    logic       read_n_q, read_n_d;
    logic [7:0] r_addr_q, r_addr_d;
    logic       x_ready_q, x_ready_d;
    logic       res_valid_q, res_valid_d;
    logic [8:0] res_data_q, res_data_d;
    logic [7:0] res_addr_q, res_addr_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       xfer;

    assign xfer = bus.x_valid & x_ready_q;

    // Next state, data path captures, and Moore outputs decoded from the next state
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        x_load_d      = x_load_q;
        valid_input_d = 1'b0;
        r_addr_d      = r_addr_q;
        res_data_d    = res_data_q;
        res_addr_d    = res_addr_q;

        unique case (state)
            IDLE: begin
                if (bus.job_go) state_d = START;
            end
            START: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                // The cycle in which cnt reaches X_CNT carries the final valid_input pulse
                if (cnt == CW'(X_CNT)) begin
                    state_d = WAIT_FIN;
                end else if (xfer) begin
                    x_load_d      = bus.x_data;
                    valid_input_d = 1'b1;
                    cnt_d         = cnt + CW'(1);
                end
            end
            WAIT_FIN: begin
                if (bus.finish) begin
                    state_d  = RD_REQ;
                    r_addr_d = '0;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.ry) begin
                    res_data_d = bus.read_data;
                    res_addr_d = r_addr_q;
                    state_d    = RD_OUT;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            RD_OUT: begin
                if (bus.res_ready) begin
                    if (r_addr_q == 8'(RES_CNT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        r_addr_d = r_addr_q + 8'd1;
                        state_d  = RD_REQ;
                    end
                end
            end
            ERR: begin
            end
        endcase

        // Timeout counter restarts on every state change and only runs while waiting on the chip
        tmo_d = '0;
        if ((state_d == state) && ((state == WAIT_FIN) || (state == RD_WAIT))) begin
            tmo_d = tmo + TW'(1);
        end

        start_in_d  = (state_d == START);
        x_ready_d   = (state_d == LOAD) && (cnt_d != CW'(X_CNT));
        read_n_d    = !((state_d == RD_REQ) || (state_d == RD_WAIT));
        res_valid_d = (state_d == RD_OUT);
        busy_d      = (state_d != IDLE);
        err_d       = (state_d == ERR);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            tmo           <= '0;
            start_in_q    <= 1'b0;
            valid_input_q <= 1'b0;
            x_load_q      <= 8'h00;
            read_n_q      <= 1'b1;
            r_addr_q      <= 8'h00;
            x_ready_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= 9'h000;
            res_addr_q    <= 8'h00;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            tmo           <= tmo_d;
            start_in_q    <= start_in_d;
            valid_input_q <= valid_input_d;
            x_load_q      <= x_load_d;
            read_n_q      <= read_n_d;
            r_addr_q      <= r_addr_d;
            x_ready_q     <= x_ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_addr_q    <= res_addr_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign bus.start_in    = start_in_q;
    assign bus.valid_input = valid_input_q;
    assign bus.X_load      = x_load_q;
    assign bus.read_n      = read_n_q;
    assign bus.r_addr      = r_addr_q;
    assign bus.x_ready     = x_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_icp_host_driver.sv
// Directed bench for icp_host_driver: loads, reads, stalls, mid-job reset and timeout.
module tb_icp_host_driver;
    localparam int X_CNT   = 4;
    localparam int RES_CNT = 4;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst;
    icp_host_if bus();

    icp_host_driver #(
        .X_CNT  (X_CNT),
        .RES_CNT(RES_CNT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] xb     [X_CNT];
    logic [8:0] rd_tbl [RES_CNT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 32'({bus.start_in, bus.valid_input, bus.x_ready, bus.res_valid,
                                  bus.busy, bus.err, bus.read_n}), 32'h1);
        check({tag, "_xload"}, 32'(bus.X_load), 32'h0);
        check({tag, "_raddr"}, 32'(bus.r_addr), 32'h0);
        check({tag, "_res"}, 32'({bus.res_addr, bus.res_data}), 32'h0);
    endtask

    task automatic start_job();
        @(negedge clk);
        bus.job_go = 1'b1;
        @(negedge clk);
        check("start_on", 32'({bus.start_in, bus.busy}), 32'h3);
        bus.job_go = 1'b0;
    endtask

    // Feed xb[] through the x stream; optionally gap x_valid and hold job_go high
    task automatic load_bytes(input bit toggle, input bit hold_go);
        int idx = 0;
        int pulses = 0;
        bus.job_go = hold_go;
        for (int c = 0; c < 40 && pulses < X_CNT; c++) begin
            @(negedge clk);
            if (c == 0) check("start_one", 32'(bus.start_in), 32'h0);
            if (bus.valid_input) begin
                check($sformatf("xload%0d", pulses), 32'(bus.X_load), 32'(xb[pulses]));
                pulses++;
                if (pulses == X_CNT) check("xrdy_last", 32'(bus.x_ready), 32'h0);
            end
            bus.x_valid = (idx < X_CNT) && (!toggle || c[0]);
            bus.x_data  = (idx < X_CNT) ? xb[idx] : 8'h00;
            if (bus.x_valid && bus.x_ready) idx++;
        end
        bus.x_valid = 1'b0;
        bus.job_go  = 1'b0;
        check("pulses", 32'(pulses), 32'(X_CNT));
        check("xfers", 32'(idx), 32'(X_CNT));
    endtask

    // Sit in WAIT_FIN with distracting inputs, raising finish on the n-th cycle
    task automatic wait_fin(input int n);
        int stray = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stray += int'(bus.valid_input) + int'(bus.x_ready) + int'(!bus.read_n) + int'(bus.err);
            bus.x_valid = 1'b1;
            bus.x_data  = 8'hEE;
            bus.ry      = 1'b1;
            if (i == n - 1) begin
                bus.finish  = 1'b1;
                bus.x_valid = 1'b0;
                bus.ry      = 1'b0;
            end
        end
        check("wait_quiet", 32'(stray), 32'h0);
    endtask

    // Chip read model (ry two cycles after each read_n fall) plus result sink
    task automatic do_reads(input int stall_at, input int abort_at);
        int   k = 0;
        int   falls = 0;
        int   age = 0;
        int   stall = 0;
        bit   seen = 1'b0;
        logic prev_rn = 1'b1;
        for (int c = 0; c < 300 && k < RES_CNT; c++) begin
            @(negedge clk);
            bus.finish    = 1'b0;
            bus.res_ready = 1'b0;
            if (!bus.read_n && prev_rn) begin
                check($sformatf("raddr%0d", falls), 32'(bus.r_addr), 32'(falls));
                falls++;
                age = 0;
            end else if (!bus.read_n) begin
                age++;
            end
            prev_rn = bus.read_n;
            if (abort_at >= 0 && falls - 1 == abort_at && !bus.read_n && age == 1) begin
                rst    = 1'b1;
                bus.ry = 1'b0;
                return;
            end
            bus.ry        = !bus.read_n && age >= 2;
            bus.read_data = 9'h000;
            if (bus.ry) bus.read_data = rd_tbl[falls - 1];
            if (bus.res_valid) begin
                if (!seen) begin
                    check($sformatf("res_addr%0d", k), 32'(bus.res_addr), 32'(k));
                    check($sformatf("res_data%0d", k), 32'(bus.res_data), 32'(rd_tbl[k]));
                    seen  = 1'b1;
                    stall = (k == stall_at) ? 5 : 0;
                end
                if (stall > 0) begin
                    check($sformatf("stall%0d", stall),
                          32'({bus.res_valid, bus.read_n, bus.r_addr, bus.res_addr, bus.res_data}),
                          32'({1'b1, 1'b1, 8'(k), 8'(k), rd_tbl[k]}));
                    stall--;
                end else begin
                    bus.res_ready = 1'b1;
                    k++;
                    seen = 1'b0;
                end
            end
        end
        check("rd_words", 32'(k), 32'(RES_CNT));
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("rd_done", 32'({bus.busy, bus.read_n, bus.res_valid, bus.err}), 32'h4);
        check("falls", 32'(falls), 32'(RES_CNT));
    endtask

    initial begin
        int rn_low = 0;
        rst           = 1'b1;
        bus.job_go    = 1'b0;
        bus.x_data    = 8'h00;
        bus.x_valid   = 1'b0;
        bus.ry        = 1'b0;
        bus.read_data = 9'h000;
        bus.finish    = 1'b0;
        bus.res_ready = 1'b0;
        rd_tbl[0] = 9'h1FF;
        rd_tbl[1] = 9'h000;
        rd_tbl[2] = 9'h0A5;
        rd_tbl[3] = 9'h15A;

        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Continuous load, finish after 10 cycles, unstalled readback
        xb[0] = 8'h11; xb[1] = 8'h22; xb[2] = 8'h33; xb[3] = 8'h44;
        start_job();
        load_bytes(1'b0, 1'b0);
        wait_fin(10);
        do_reads(-1, -1);

        // Gapped x_valid with job_go held high, result sink stalls on word 2
        xb[0] = 8'hA1; xb[1] = 8'h5B; xb[2] = 8'hFF; xb[3] = 8'h00;
        start_job();
        load_bytes(1'b1, 1'b1);
        wait_fin(3);
        do_reads(2, -1);

        // Reset while waiting on ry for address 1, then a fresh job
        start_job();
        load_bytes(1'b0, 1'b0);
        wait_fin(4);
        do_reads(-1, 1);
        @(negedge clk);
        check_idle("abort");
        rst = 1'b0;
        start_job();
        load_bytes(1'b0, 1'b0);
        wait_fin(2);
        do_reads(0, -1);

        // finish never comes: err exactly TIMEOUT cycles into WAIT_FIN, and sticky
        start_job();
        load_bytes(1'b0, 1'b0);
        for (int i = 0; i <= TIMEOUT; i++) begin
            @(negedge clk);
            rn_low += int'(!bus.read_n);
            if (i == TIMEOUT - 1) check("err_early", 32'(bus.err), 32'h0);
            if (i == TIMEOUT) check("err_set", 32'({bus.err, bus.busy}), 32'h3);
        end
        check("tmo_readn", 32'(rn_low), 32'h0);
        bus.finish = 1'b1;
        bus.job_go = 1'b1;
        bus.ry     = 1'b1;
        repeat (3) @(negedge clk);
        check("err_sticky", 32'({bus.err, bus.read_n, bus.start_in, bus.valid_input,
                                 bus.x_ready, bus.res_valid}), 32'h30);
        bus.finish = 1'b0;
        bus.job_go = 1'b0;
        bus.ry     = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check_idle("rst_err");
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icp_host_driver.md
ICP_HOST_DRIVER -- requirements
Module: icp_host_driver

Interface
REQ-001 SHALL have parameter X_CNT, default 64: number of X bytes loaded per job.
REQ-002 SHALL have parameter RES_CNT, default 16: number of result words read back per job (addresses 0..RES_CNT-1, max 256).
REQ-003 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for finish or ry.
REQ-004 SHALL have port clk, in, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-006 SHALL have port job_go, in, 1: one-cycle request to run one job; honoured only in IDLE.
REQ-007 SHALL have ports x_data, in, 8 and x_valid, in, 1: source stream of X bytes.
REQ-008 SHALL have port x_ready, out, 1: high only in LOAD; a byte transfers when x_valid & x_ready.
REQ-009 SHALL have port start_in, out, 1: chip start pulse.
REQ-010 SHALL have ports X_load, out, 8 and valid_input, out, 1: chip X-load bus and strobe.
REQ-011 SHALL have ports read_n, out, 1 (active-low read request) and r_addr, out, 8.
REQ-012 SHALL have ports ry, in, 1; read_data, in, 9; finish, in, 1: chip read-ready, read data, done flag.
REQ-013 SHALL have ports res_data, out, 9; res_addr, out, 8; res_valid, out, 1; res_ready, in, 1: result stream.
REQ-014 SHALL have ports busy, out, 1 (state != IDLE) and err, out, 1 (sticky timeout flag).

Function
REQ-015 SHALL implement states IDLE, START, LOAD, WAIT_FIN, RD_REQ, RD_WAIT, RD_OUT, ERR.
REQ-016 IDLE -> START on job_go; job_go in any other state SHALL be ignored.
REQ-017 START SHALL drive start_in=1 for exactly one cycle, then enter LOAD.
REQ-018 LOAD: on each x_valid&x_ready, the following cycle SHALL present the byte on X_load with valid_input=1 for exactly one cycle; X_load holds its last value otherwise.
REQ-019 LOAD SHALL count transfers 0..X_CNT-1; after the X_CNT-th valid_input pulse, go to WAIT_FIN; x_ready SHALL be 0 in the cycle its count reaches X_CNT.
REQ-020 x_valid low in LOAD SHALL stall without timeout; valid_input stays 0.
REQ-021 WAIT_FIN: finish=1 -> RD_REQ with r_addr=0; TIMEOUT cycles without finish -> ERR.
REQ-022 RD_REQ: drive read_n=0 with stable r_addr for one cycle, then RD_WAIT.
REQ-023 RD_WAIT: hold read_n=0; on ry=1 capture read_data into res_data, r_addr into res_addr, release read_n=1, go RD_OUT; TIMEOUT cycles without ry -> ERR.
REQ-024 RD_OUT: res_valid=1, res_data/res_addr stable until res_ready; on res_valid&res_ready: if r_addr==RES_CNT-1 -> IDLE, else r_addr+1 -> RD_REQ.
REQ-025 read_n SHALL be 1 for at least one cycle between consecutive reads.
REQ-026 r_addr SHALL not wrap; RES_CNT-1 is the last address issued.
REQ-027 Timeout counter SHALL clear on every state entry; it counts only in WAIT_FIN and RD_WAIT.
REQ-028 ERR: err=1, read_n=1, all strobes 0; leaves only via rst.
REQ-029 finish/ry asserted in states other than WAIT_FIN/RD_WAIT SHALL be ignored.

Reset
REQ-030 On rst: state IDLE, start_in=0, valid_input=0, X_load=0, read_n=1, r_addr=0, x_ready=0, res_valid=0, res_data=0, res_addr=0, busy=0, err=0, counters 0.
REQ-031 rst mid-job SHALL abort immediately; next cycle outputs equal REQ-030 values.

Verification
REQ-032 job_go, X_CNT=4, bytes 0x11,0x22,0x33,0x44 continuous -> start_in one cycle, then four valid_input pulses carrying those bytes, state WAIT_FIN.
REQ-033 finish after 10 cycles, ry 2 cycles after each read_n fall, read_data=0x1FF,0x000,... -> res stream addr 0..RES_CNT-1 with matching data, then busy=0.
REQ-034 x_valid toggled every other cycle -> exactly X_CNT valid_input pulses, no duplicates or drops, no err.
REQ-035 finish never asserted -> err=1 after TIMEOUT cycles in WAIT_FIN; read_n stays 1.
REQ-036 res_ready held 0 for 5 cycles -> res_valid/res_data stable, r_addr not advanced.
REQ-037 rst asserted during RD_WAIT -> read_n=1, busy=0 next cycle; new job_go runs to completion.
